// File: rtl/rv_pkg.sv
// Shared RISC-V core types for the writeback path.
// Register-file geometry and the writeback request bundle.
package rv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    // One-hot of a destination register; x0 never marks as pending.
    function automatic logic [NUM_REGS-1:0] rd_onehot(
        input logic [REG_ADDR_W-1:0] rd
    );
        logic [NUM_REGS-1:0] m;
        m     = '0;
        m[rd] = 1'b1;
        m[0]  = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Load-return queue for the writeback arbiter.
// Circular buffer with per-entry valid bits for hazard tracking.
module wb_fifo
    import rv_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = wb_req_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  T                         push_data,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output T                         head,
    output logic [$clog2(DEPTH)-1:0] head_idx,
    output logic [DEPTH-1:0]         entry_valid,
    output logic [REG_ADDR_W-1:0]    entry_rd [DEPTH]
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    T              mem [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full     = (count == (PW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head     = mem[rd_ptr];
    assign head_idx = rd_ptr;

    for (genvar i = 0; i < DEPTH; i++) begin : g_rd
        assign entry_rd[i] = mem[i].rd;
    end

    // Pointers, occupancy and per-entry valid bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            entry_valid <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr              <= rd_ptr + 1'b1;
                entry_valid[rd_ptr] <= 1'b0;
            end
            if (do_push) begin
                wr_ptr              <= wr_ptr + 1'b1;
                entry_valid[wr_ptr] <= 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are qualified by entry_valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter between ALU and load returns.
// Optional head aging enabled by macro RF_WB_AGING_EN.
module rf_wb_arbiter
    import rv_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter int AGE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    output logic                  alu_ready,
    input  logic                  ld_valid,
    input  logic [REG_ADDR_W-1:0] ld_rd,
    input  logic [XLEN-1:0]       ld_data,
    output logic                  ld_ready,
    output logic                  rf_en,
    output logic [REG_ADDR_W-1:0] rf_rd,
    output logic [XLEN-1:0]       rf_data,
    output logic [NUM_REGS-1:0]   pend_mask
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || AGE_LIMIT < 1)
    begin : g_bad_param
        $error("rf_wb_arbiter: invalid DEPTH or AGE_LIMIT");
    end

    localparam int PW = $clog2(DEPTH);

    logic                  full;
    logic                  empty;
    wb_req_t               head;
    logic [PW-1:0]         head_idx;
    logic [DEPTH-1:0]      entry_valid;
    logic [REG_ADDR_W-1:0] entry_rd [DEPTH];

    logic          push;
    logic          alu_fire;
    logic          head_grant;
    wb_req_t       grant;
    logic          wr_en;
    logic [NUM_REGS-1:0] pend_next;

    assign ld_ready   = !full;
    assign push       = ld_valid && ld_ready;
    assign alu_fire   = alu_valid && alu_ready;
    assign head_grant = !empty && !alu_fire;
    assign grant      = alu_fire ? wb_req_t'{rd: alu_rd, data: alu_data}
                                 : head;
    assign wr_en      = (alu_fire || head_grant) && (grant.rd != '0);

    wb_fifo #(
        .DEPTH (DEPTH),
        .T     (wb_req_t)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_data   (wb_req_t'{rd: ld_rd, data: ld_data}),
        .pop         (head_grant),
        .full        (full),
        .empty       (empty),
        .head        (head),
        .head_idx    (head_idx),
        .entry_valid (entry_valid),
        .entry_rd    (entry_rd)
    );

`ifdef RF_WB_AGING_EN
    localparam int AW = $clog2(AGE_LIMIT + 1);

    logic [AW-1:0] age;

    // A starved head blocks the ALU for one cycle to force its grant.
    assign alu_ready = (age != AW'(AGE_LIMIT));

    // Count cycles the head waits; clear on grant or when drained.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            age <= '0;
        end else if (empty || head_grant) begin
            age <= '0;
        end else if (age != AW'(AGE_LIMIT)) begin
            age <= age + 1'b1;
        end
    end
`else
    assign alu_ready = 1'b1;
`endif

    // Pending set as it will stand after this edge.
    always_comb begin
        pend_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] &&
                !(head_grant && head_idx == PW'(i))) begin
                pend_next = pend_next | rd_onehot(entry_rd[i]);
            end
        end
        if (push) begin
            pend_next = pend_next | rd_onehot(ld_rd);
        end
        if (wr_en) begin
            pend_next = pend_next | rd_onehot(grant.rd);
        end
        pend_next[0] = 1'b0;
    end

    // Output stage: one-cycle write pulse, address/data hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_en     <= 1'b0;
            rf_rd     <= '0;
            rf_data   <= '0;
            pend_mask <= '0;
        end else begin
            rf_en     <= wr_en;
            pend_mask <= pend_next;
            if (wr_en) begin
                rf_rd   <= grant.rd;
                rf_data <= grant.data;
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed scoreboard bench for rf_wb_arbiter.
// Aging scenario runs only when RF_WB_AGING_EN is defined.
module tb_rf_wb_arbiter;
    import rv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        rf_en;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data;
    logic [31:0] pend_mask;

    int errors = 0;
    int checks = 0;
    wb_req_t exp_q[$];
    logic [4:0]  last_rd;
    logic [31:0] last_data;

    rf_wb_arbiter #(
        .DEPTH     (2),
        .AGE_LIMIT (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .ld_valid  (ld_valid),
        .ld_rd     (ld_rd),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .rf_en     (rf_en),
        .rf_rd     (rf_rd),
        .rf_data   (rf_data),
        .pend_mask (pend_mask)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: observed no end expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
        exp_q.push_back(wb_req_t'{rd: rd, data: d});
        last_rd   = rd;
        last_data = d;
    endtask

    // One clock: check any write pulse against the scoreboard.
    task automatic cyc();
        wb_req_t e;
        @(negedge clk);
        if (rf_en === 1'b1) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL wr_unexpected: observed rd=%0d data=%h expected none",
                       rf_rd, rf_data);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                assert ({rf_rd, rf_data} === {e.rd, e.data}) else begin
                    errors++;
                    $error("FAIL wr_order: observed rd=%0d data=%h expected rd=%0d data=%h",
                           rf_rd, rf_data, e.rd, e.data);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag, input int n);
        repeat (n) cyc();
        chk(tag, exp_q.size(), 0);
    endtask

    initial begin
        int acc;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        ld_valid  = 0; ld_rd  = 0; ld_data  = 0;
        last_rd = 0; last_data = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rf_en", rf_en, 0);
        chk("rst_rf_rd", rf_rd, 0);
        chk("rst_rf_data", rf_data, 0);
        chk("rst_pend", pend_mask, 0);
        chk("rst_ld_ready", ld_ready, 1);
        chk("rst_alu_ready", alu_ready, 1);
        rst = 1'b0;
        chk("rel_ld_ready", ld_ready, 1);
        chk("rel_alu_ready", alu_ready, 1);
        cyc();
        chk("idle_rf_en", rf_en, 0);

        // ALU-only stream to x5
        alu_valid = 1; alu_rd = 5;
        for (int i = 0; i < 3; i++) begin
            alu_data = 32'hA5A5_0001 + i;
            chk("alu_ready", alu_ready, 1);
            chk("alu_ld_ready", ld_ready, 1);
            expect_wr(5, alu_data);
            cyc();
            chk("alu_rf_en", rf_en, 1);
            chk("alu_rf_rd", rf_rd, 5);
        end
        alu_valid = 0;
        cyc();
        chk("alu_stop_rf_en", rf_en, 0);
        chk("alu_hold_rd", rf_rd, 5);
        chk("alu_hold_data", rf_data, 32'hA5A5_0003);
        drain("alu_drain", 2);

        // Load x7 waits behind two ALU writes to x3
        ld_valid = 1; ld_rd = 7; ld_data = 32'h11;
        chk("cont_ld_ready", ld_ready, 1);
        cyc();
        ld_valid = 0;
        chk("cont_pend7_q", pend_mask[7], 1);
        alu_valid = 1; alu_rd = 3; alu_data = 32'h3333_0001;
        expect_wr(3, alu_data);
        cyc();
        chk("cont_pend7_a", pend_mask[7], 1);
        chk("cont_pend3", pend_mask[3], 1);
        alu_data = 32'h3333_0002;
        expect_wr(3, alu_data);
        cyc();
        alu_valid = 0;
        expect_wr(7, 32'h11);
        chk("cont_pend7_b", pend_mask[7], 1);
        cyc();
        chk("cont_rf_en7", rf_en, 1);
        chk("cont_rf_rd7", rf_rd, 7);
        chk("cont_pend7_w", pend_mask[7], 1);
        cyc();
        chk("cont_pend7_clr", pend_mask[7], 0);
        chk("cont_rf_en_off", rf_en, 0);
        drain("cont_drain", 2);

`ifndef RF_WB_AGING_EN
        // Three loads into a 2-deep FIFO while the ALU saturates
        alu_valid = 1; alu_rd = 9; ld_valid = 1;
        for (int i = 0; i < 3; i++) begin
            alu_data = 32'h9000_0000 + i;
            ld_rd    = 5'(10 + i);
            ld_data  = 32'h0010_0000 + i;
            chk("full_ld_ready", ld_ready, (i < 2) ? 1 : 0);
            expect_wr(9, alu_data);
            cyc();
        end
        alu_valid = 0;
        chk("full_ld_ready_hold", ld_ready, 0);
        for (int i = 0; i < 3; i++) begin
            expect_wr(5'(10 + i), 32'h0010_0000 + i);
        end
        cyc();
        chk("full_ld_ready_free", ld_ready, 1);
        cyc();
        ld_valid = 0;
        chk("full_rf_rd_l1", rf_rd, 11);
        drain("full_drain", 4);
`endif

        // x0 writes from both sources are consumed silently
        alu_valid = 1; alu_rd = 0; alu_data = 32'hDEAD_0000;
        ld_valid  = 1; ld_rd  = 0; ld_data  = 32'hBEEF_0000;
        chk("x0_ld_ready", ld_ready, 1);
        cyc();
        alu_valid = 0; ld_valid = 0;
        chk("x0_pend0", pend_mask[0], 0);
        chk("x0_rf_en_a", rf_en, 0);
        cyc();
        chk("x0_rf_en_b", rf_en, 0);
        chk("x0_hold_rd", rf_rd, last_rd);
        chk("x0_hold_data", rf_data, last_data);
        chk("x0_pend", pend_mask, 0);
        drain("x0_drain", 2);

`ifdef RF_WB_AGING_EN
        // Starved load head forces one ALU stall
        alu_valid = 1; alu_rd = 6;
        ld_valid = 1; ld_rd = 8; ld_data = 32'h88;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            if (i == 1) ld_valid = 0;
            alu_data = 32'h6000_0000 + acc;
            chk("age_alu_ready", alu_ready, (i != 5) ? 1 : 0);
            if (i == 5) begin
                expect_wr(8, 32'h88);
            end else begin
                expect_wr(6, alu_data);
                acc++;
            end
            cyc();
        end
        alu_valid = 0;
        drain("age_drain", 3);
`endif

        // Reset with two queued loads and a write in flight
        alu_valid = 1; alu_rd = 4; alu_data = 32'h4444_0001;
        ld_valid = 1; ld_rd = 20; ld_data = 32'h20;
        expect_wr(4, alu_data);
        cyc();
        ld_rd = 21; ld_data = 32'h21; alu_data = 32'h4444_0002;
        cyc();
        chk("mid_rf_en", rf_en, 1);
        chk("mid_pend21", pend_mask[21], 1);
        rst = 1'b1;
        alu_valid = 0; ld_valid = 0;
        #1;
        chk("mid_rst_rf_en", rf_en, 0);
        chk("mid_rst_rf_rd", rf_rd, 0);
        chk("mid_rst_rf_data", rf_data, 0);
        chk("mid_rst_pend", pend_mask, 0);
        chk("mid_rst_ld_ready", ld_ready, 1);
        chk("mid_rst_alu_ready", alu_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rel_alu_ready", alu_ready, 1);
        chk("mid_rel_ld_ready", ld_ready, 1);
        drain("mid_drain", 4);
        chk("mid_final_pend", pend_mask, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameter DEPTH, default 2: load-return FIFO entries; a power of two and at least 2.
REQ-002 Parameter AGE_LIMIT, default 4: cycles a waiting load head may be bypassed before it is forced (aging build only).
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 alu_valid  in  1  ALU/pipeline writeback request this cycle.
REQ-006 alu_rd  in  5  ALU destination register.
REQ-007 alu_data  in  32  ALU writeback data.
REQ-008 alu_ready  out  1  ALU request is accepted this cycle; pipeline stalls when low.
REQ-009 ld_valid  in  1  load-unit return valid.
REQ-010 ld_rd  in  5  load destination register.
REQ-011 ld_data  in  32  load return data.
REQ-012 ld_ready  out  1  FIFO can accept a load return this cycle.
REQ-013 rf_en  out  1  register-file write enable.
REQ-014 rf_rd  out  5  register-file write address.
REQ-015 rf_data  out  32  register-file write data.
REQ-016 pend_mask  out  32  bit r set while a write to xr is queued or on the rf_* outputs.

Function
REQ-017 Load returns: enqueued when ld_valid && ld_ready; ld_ready = !full, derived from state only.
REQ-018 Full FIFO: ld_ready low even if the head dequeues that cycle; no same-cycle refill.
REQ-019 Enqueue into an empty FIFO: entry becomes head next cycle; no bypass.
REQ-020 Grant: at most one write per cycle, ALU (alu_valid && alu_ready) or FIFO head.
REQ-021 Default priority: ALU over FIFO head; head granted whenever no ALU transfer occurs.
REQ-022 alu_ready: combinational from registered state only, never from alu_valid.
REQ-023 Output stage: granted rd/data registered onto rf_rd/rf_data; rf_en high for exactly the next cycle.
REQ-024 rd == 0 grant: entry consumed, alu_ready honoured; rf_en stays low and rf_rd/rf_data hold.
REQ-025 No grant: rf_en low next cycle; rf_rd/rf_data hold.
REQ-026 Order: load returns reach rf_* in enqueue order; ALU writes in acceptance order.
REQ-027 pend_mask: OR of one-hot(rd) over valid FIFO entries and the output stage when rf_en; bit 0 always 0; registered.
REQ-028 FIFO pointers: wrap modulo DEPTH; occupancy never exceeds DEPTH and never goes negative.

Reset
REQ-029 On rst: FIFO empty, age = 0, rf_en = 0, rf_rd = 0, rf_data = 0, pend_mask = 0.
REQ-030 Reset values: ld_ready = 1 and alu_ready = 1 while rst is high and on the first cycle after release.
REQ-031 Reset mid-operation: queued loads and the in-flight output write are discarded; no rf_en pulse after rst.

Configuration
REQ-032 Macro RF_WB_AGING_EN defined: a counter increments each cycle the head is valid and not granted, and clears on head grant or when the FIFO is empty.
REQ-033 With RF_WB_AGING_EN defined, age == AGE_LIMIT: alu_ready = 0 and the head is granted that cycle.
REQ-034 RF_WB_AGING_EN undefined: no counter; alu_ready is constant 1 and the ALU has strict priority.

Structure
REQ-035 Package rv_pkg: XLEN = 32, REG_ADDR_W = 5, NUM_REGS = 32, struct wb_req_t {rd, data}.
REQ-036 Sub-module wb_fifo: parameterised by DEPTH and element type wb_req_t; exposes full, empty, head and per-entry valid/rd for pend_mask.
REQ-037 Arbiter, aging counter and output stage live in rf_wb_arbiter.

Verification
REQ-038 ALU-only: alu_valid with rd=5, data=0xA5A5_0001 for 3 cycles -> rf_en 1 for 3 cycles starting one cycle later, rf_rd 5, ld_ready 1.
REQ-039 Contention: load rd=7, data=0x11 enqueued, then ALU rd=3 valid for 2 cycles -> x3 written twice, then x7; pend_mask[7] high until the x7 write completes.
REQ-040 Aging, RF_WB_AGING_EN, AGE_LIMIT=4: continuous ALU traffic plus one load -> alu_ready low exactly one cycle, 4 cycles after the load becomes head; load written next cycle.
REQ-041 Full FIFO, DEPTH=2: three back-to-back loads with ALU saturating and aging off -> ld_ready low on the third; writes are issued in order once the ALU idles.
REQ-042 x0 writes: ALU rd=0 and load rd=0 -> both consumed, rf_en never high, pend_mask[0] = 0.
REQ-043 Reset: rst asserted with 2 queued loads and rf_en high -> all outputs reach reset values immediately; no writes after release without new requests.
